jk_response_checker: RTL and testbench

//  Synthesizable self-checking monitor for a JK flip-flop DUT (sync-reset flavour).

---
 rtl/jk_chk_pkg.sv | 30 +++
 rtl/jk_response_checker_if.sv | 28 ++
 rtl/jk_ref_model.sv | 27 ++
 rtl/jk_response_checker.sv | 107 ++++++++++
 tb/tb_jk_response_checker.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/jk_chk_pkg.sv
// Shared types and helpers for the JK flip-flop response checker.
// Build option: JK_CHK_STOP_ON_FAIL_EN (see jk_response_checker.sv).
package jk_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jk_nxt(input logic q, input logic [1:0] jk);
        logic q_n;
        q_n = q;
        case (jk)
            JK_HOLD: q_n = q;
            JK_RST:  q_n = 1'b0;
            JK_SET:  q_n = 1'b1;
            JK_TGL:  q_n = ~q;
            default: q_n = q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_response_checker_if.sv
// Stimulus / verdict bundle between the JK checker and its environment.
// Build option: JK_CHK_STOP_ON_FAIL_EN (no effect on this interface).
interface jk_response_checker_if #(parameter int CNT_W = 8);

    logic             en;
    logic             J;
    logic             K;
    logic             q_dut;
    logic             q_ref;
    logic             mismatch;
    logic             fail;
    logic             done;
    logic [1:0]       state;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_fail_cyc;

    modport master (
        output en, J, K, q_dut,
        input  q_ref, mismatch, fail, done, state, chk_cnt, err_cnt, first_fail_cyc
    );

    modport slave (
        input  en, J, K, q_dut,
        output q_ref, mismatch, fail, done, state, chk_cnt, err_cnt, first_fail_cyc
    );

endinterface

// File: rtl/jk_ref_model.sv
// Golden JK flop; load_i re-seeds the model from the DUT's present Q.
// Build option: JK_CHK_STOP_ON_FAIL_EN (no effect on this module).
module jk_ref_model
    import jk_chk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic load_val_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_ref_o
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= jk_nxt(load_i ? load_val_i : q_q, {j_i, k_i});
        end
    end

    assign q_ref_o = q_q;

endmodule

// File: rtl/jk_response_checker.sv
// Run-controlled compare of a JK DUT's Q against a golden model, with counters and verdict.
// Build option: define JK_CHK_STOP_ON_FAIL_EN to end the run at the first mismatch.
module jk_response_checker
    import jk_chk_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int N_CHECKS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    jk_response_checker_if.slave  bus
);

    // state | meaning
    // IDLE  | model free-runs, waiting for en
    // SEED  | one cycle: model re-aligned to the DUT's present Q
    // CHECK | one compare per edge until N_CHECKS or en drops
    // DONE  | verdict frozen, model keeps tracking

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_CHECKS);

    chk_state_e       state_q;
    logic [CNT_W-1:0] chk_cnt_q;
    logic [CNT_W-1:0] chk_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] first_fail_q;
    logic             fail_q;
    logic             mismatch_q;
    logic             miss;

    jk_ref_model u_ref (
        .clk        (clk),
        .reset      (reset),
        .load_i     (state_q == SEED),
        .load_val_i (bus.q_dut),
        .j_i        (bus.J),
        .k_i        (bus.K),
        .q_ref_o    (bus.q_ref)
    );

    assign miss      = (bus.q_dut != bus.q_ref);
    assign chk_cnt_d = chk_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            chk_cnt_q    <= '0;
            err_cnt_q    <= '0;
            first_fail_q <= '0;
            fail_q       <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        state_q      <= SEED;
                        chk_cnt_q    <= '0;
                        err_cnt_q    <= '0;
                        first_fail_q <= '0;
                        fail_q       <= 1'b0;
                    end
                end
                SEED: state_q <= CHECK;
                CHECK: begin
                    // Dropping en abandons the run; this edge's compare is not counted.
                    if (!bus.en) begin
                        state_q <= IDLE;
                    end else begin
                        chk_cnt_q <= chk_cnt_d;
                        if (miss) begin
                            mismatch_q <= 1'b1;
                            err_cnt_q  <= err_cnt_q + 1'b1;
                            fail_q     <= 1'b1;
                            if (!fail_q) begin
                                first_fail_q <= chk_cnt_q;
                            end
                        end
                        if (chk_cnt_d == N_LAST) begin
                            state_q <= DONE;
                        end
`ifdef JK_CHK_STOP_ON_FAIL_EN
                        if (miss) begin
                            state_q <= DONE;
                        end
`endif
                    end
                end
                DONE: begin
                    if (!bus.en) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.state          = state_q;
    assign bus.done           = (state_q == DONE);
    assign bus.mismatch       = mismatch_q;
    assign bus.fail           = fail_q;
    assign bus.chk_cnt        = chk_cnt_q;
    assign bus.err_cnt        = err_cnt_q;
    assign bus.first_fail_cyc = first_fail_q;

endmodule

// File: tb/tb_jk_response_checker.sv
// Scoreboard bench for jk_response_checker: directed scenarios plus randomized traffic.
// Build option: JK_CHK_STOP_ON_FAIL_EN changes the expected run length after a mismatch.
module tb_jk_response_checker;

    localparam int CNT_W    = 8;
    localparam int N_CHECKS = 16;

    typedef struct packed {
        bit       q;
        bit       mis;
        bit       fail;
        bit       done;
        bit [1:0] st;
        bit [7:0] chk;
        bit [7:0] err;
        bit [7:0] ff;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Behavioural DUT flop and reference-model bookkeeping
    bit   dut_q = 0;
    int   m_phase = 0;   // 0 idle, 1 seed, 2 checking, 3 finished
    bit   m_q = 0;
    bit   m_mis = 0;
    bit   m_fail = 0;
    int   m_chk = 0;
    int   m_err = 0;
    int   m_ff = 0;
    bit   stop_on_fail;

    jk_response_checker_if #(.CNT_W(CNT_W)) bus ();

    jk_response_checker #(.CNT_W(CNT_W), .N_CHECKS(N_CHECKS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit jk(input bit q, input bit j, input bit k);
        if (j && k) return !q;
        if (j) return 1'b1;
        if (k) return 1'b0;
        return q;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: what a JK checker must report after one clock, given pre-edge inputs.
    function automatic void model_edge(input bit r, input bit e, input bit j, input bit k, input bit qd);
        bit bad;
        m_mis = 0;
        if (r) begin
            m_phase = 0; m_q = 0; m_fail = 0; m_chk = 0; m_err = 0; m_ff = 0;
            return;
        end
        bad = (qd != m_q);
        if (m_phase == 1) m_q = jk(qd, j, k);
        else              m_q = jk(m_q, j, k);
        if (m_phase == 0) begin
            if (e) begin
                m_phase = 1; m_chk = 0; m_err = 0; m_fail = 0; m_ff = 0;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (!e) begin
                m_phase = 0;
            end else begin
                if (bad) begin
                    if (!m_fail) m_ff = m_chk;
                    m_fail = 1;
                    m_err++;
                    m_mis = 1;
                end
                m_chk++;
                if (m_chk == N_CHECKS || (bad && stop_on_fail)) m_phase = 3;
            end
        end else if (!e) begin
            m_phase = 0;
        end
    endfunction

    task automatic step(input bit r, input bit e, input bit j, input bit k, input bit stuck, input bit inj);
        bit qd;
        exp_t x;
        @(negedge clk);
        qd = stuck ? 1'b0 : (dut_q ^ inj);
        reset = r; bus.en = e; bus.J = j; bus.K = k; bus.q_dut = qd;
        @(posedge clk);
        model_edge(r, e, j, k, qd);
        dut_q = r ? 1'b0 : jk(dut_q, j, k);
        x.q = m_q; x.mis = m_mis; x.fail = m_fail; x.done = (m_phase == 3);
        x.st = 2'(m_phase); x.chk = 8'(m_chk); x.err = 8'(m_err); x.ff = 8'(m_ff);
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q_ref", {31'd0, bus.q_ref}, {31'd0, e.q});
            check("mismatch", {31'd0, bus.mismatch}, {31'd0, e.mis});
            check("fail", {31'd0, bus.fail}, {31'd0, e.fail});
            check("done", {31'd0, bus.done}, {31'd0, e.done});
            check("state", {30'd0, bus.state}, {30'd0, e.st});
            check("chk_cnt", {24'd0, bus.chk_cnt}, {24'd0, e.chk});
            check("err_cnt", {24'd0, bus.err_cnt}, {24'd0, e.err});
            check("first_fail_cyc", {24'd0, bus.first_fail_cyc}, {24'd0, e.ff});
        end
    end

    initial begin
        bit [1:0] pat [6];
        bit e;
`ifdef JK_CHK_STOP_ON_FAIL_EN
        stop_on_fail = 1;
`else
        stop_on_fail = 0;
`endif
        pat = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b01, 2'b11};
        reset = 1; bus.en = 1; bus.J = 1; bus.K = 0; bus.q_dut = 0;

        // Reset with en=1, J=1, K=0
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        #1;
        check("t1_state", {30'd0, bus.state}, 0);
        check("t1_q_ref", {31'd0, bus.q_ref}, 0);
        check("t1_chk_cnt", {24'd0, bus.chk_cnt}, 0);
        check("t1_done", {31'd0, bus.done}, 0);
        step(0, 0, 0, 0, 0, 0);

        // Correct DUT, repeating pattern: done 17 edges after en sampled
        for (int i = 0; i < 17; i++) step(0, 1, pat[i % 6][1], pat[i % 6][0], 0, 0);
        #1 check("t2_done_early", {31'd0, bus.done}, 0);
        step(0, 1, pat[17 % 6][1], pat[17 % 6][0], 0, 0);
        #1;
        check("t2_done", {31'd0, bus.done}, 1);
        check("t2_chk_cnt", {24'd0, bus.chk_cnt}, 16);
        check("t2_err_cnt", {24'd0, bus.err_cnt}, 0);
        step(0, 0, 0, 0, 0, 0);

        // Stuck-at-0 DUT with J=1, K=0
        for (int i = 0; i < 18; i++) step(0, 1, 1, 0, 1, 0);
        #1;
        check("t3_err_cnt", {24'd0, bus.err_cnt}, stop_on_fail ? 1 : 16);
        check("t3_first_fail", {24'd0, bus.first_fail_cyc}, 0);
        check("t3_fail", {31'd0, bus.fail}, 1);
        step(0, 0, 0, 0, 0, 0);

        // Toggle mode, one inversion at compare 9
        for (int i = 0; i < 18; i++) step(0, 1, 1, 1, 0, i == 11);
        #1;
        check("t4_err_cnt", {24'd0, bus.err_cnt}, 1);
        check("t4_first_fail", {24'd0, bus.first_fail_cyc}, 9);
        step(0, 0, 0, 0, 0, 0);

        // Drop en after compare 7
        for (int i = 0; i < 9; i++) step(0, 1, 1'($urandom), 1'($urandom), 0, 0);
        step(0, 0, 1'($urandom), 1'($urandom), 0, 0);
        #1;
        check("t5_state", {30'd0, bus.state}, 0);
        check("t5_chk_held", {24'd0, bus.chk_cnt}, 7);
        step(0, 1, 0, 0, 0, 0);
        #1 check("t5_chk_clear", {24'd0, bus.chk_cnt}, 0);

        // Reset at compare 5
        for (int i = 0; i < 6; i++) step(0, 1, 1'($urandom), 1'($urandom), 0, 0);
        step(1, 1, 1, 0, 0, 0);
        #1;
        check("t6_state", {30'd0, bus.state}, 0);
        check("t6_chk_cnt", {24'd0, bus.chk_cnt}, 0);
        check("t6_q_ref", {31'd0, bus.q_ref}, 0);

        // Randomized traffic
        e = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) e = !e;
            step($urandom_range(0, 149) == 0, e, 1'($urandom), 1'($urandom), 0,
                 $urandom_range(0, 19) == 0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
